// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the serial subtractor.
//   state_t   : FSM states (IDLE, RUN, DONE)
//   SLICE_W   : bits processed per clock (matches sub4_slice)
//   nslices() : number of slices needed for a given operand width
package serial_sub_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nslices(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/serial_sub_if.sv
// Operand/result handshake bundle for serial_sub.
//   in_valid/in_ready   : operand transfer (a, b, bin)
//   out_valid/out_ready : result transfer (diff, bout)
// master = producer/consumer side, slave = the subtractor.
interface serial_sub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout
    );
endinterface

// File: rtl/serial_sub_sub4_slice.sv
// sub4_slice: combinational 4-bit borrow-ripple subtractor slice.
//   x, y : minuend / subtrahend nibbles
//   bi   : borrow in
//   d    : x - y - bi (mod 16)
//   bo   : borrow out
module sub4_slice (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       bi,
    output logic [3:0] d,
    output logic       bo
);
    logic [4:0] br;

    assign br[0] = bi;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign d[i]    = x[i] ^ y[i] ^ br[i];
        assign br[i+1] = (~x[i] & y[i]) | (~x[i] & br[i]) | (y[i] & br[i]);
    end

    assign bo = br[4];
endmodule

// File: rtl/serial_sub.sv
// serial_sub: multi-cycle unsigned subtractor, diff = a - b - bin.
// One 4-bit slice per clock, LSB first; the borrow between slices is
// carried across cycles in borrow_q.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : serial_sub_if slave (operand in, result out, valid/ready)
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    serial_sub_if.slave bus
);
    localparam int NS    = nslices(WIDTH);
    localparam int CNT_W = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NS - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, diff_q;
    logic [CNT_W-1:0] cnt_q;
    logic             borrow_q, bout_q;

    logic [SLICE_W-1:0] x, y, d;
    logic               bo;

    // Single slice datapath, operand nibble selected by the slice count.
    assign x = a_q[cnt_q*SLICE_W +: SLICE_W];
    assign y = b_q[cnt_q*SLICE_W +: SLICE_W];

    sub4_slice u_slice (
        .x  (x),
        .y  (y),
        .bi (borrow_q),
        .d  (d),
        .bo (bo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)    state_d = RUN;
            RUN:     if (cnt_q == LAST)   state_d = DONE;
            DONE:    if (bus.out_ready)   state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        borrow_q <= bus.bin;
                        cnt_q    <= '0;
                    end
                end
                RUN: begin
                    diff_q[cnt_q*SLICE_W +: SLICE_W] <= d;
                    borrow_q <= bo;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST) bout_q <= bo;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
endmodule
